// File: rtl/psum_pkg.sv
// psum_pkg: shared widths, drain FSM states and a lane-slice helper for psum_drain
package psum_pkg;
  localparam int PSUM_W = 32;
  localparam int LANES = 4;
  localparam int OUT_W = 16;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic [PSUM_W-1:0] lane_of(input logic [LANES*PSUM_W-1:0] v, input int i);
    return v[PSUM_W*(LANES-1-i) +: PSUM_W];
  endfunction
endpackage

// File: rtl/psum_out_fifo.sv
// psum_out_fifo: sync FIFO; clk/rst(active-low), wr/wd push, rd_en pop, rdata/valid head (zero when empty), cnt occupancy
module psum_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 65
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [W-1:0]            wd,
  input  logic                    rd_en,
  output logic [W-1:0]            rdata,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign valid = r_cnt != '0;
  assign w_pop = rd_en && valid;
  assign w_push = wr && (r_cnt != (AW+1)'(DEPTH) || w_pop);
  assign rdata = valid ? r_mem[r_rp] : '0;
  assign cnt = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= wd;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/psum_drain.sv
// psum_drain: reads count psum entries from base_addr (re/ra/rd), adds bias, PReLU, round+saturate to 16b, streams out_data/out_last over out_valid/out_ready; busy/done status; rst active-low sync
module psum_drain
  import psum_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         count,
  input  logic [LANES*PSUM_W-1:0]   bias,
  input  logic [LANES*OUT_W-1:0]    alpha,
  input  logic                      relu_en,
  output logic                      re,
  output logic [ADDR_W-1:0]         ra,
  input  logic [LANES*PSUM_W-1:0]   rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t r_state;
  logic [ADDR_W-1:0] r_base, r_count, r_idx;
  logic [LANES*PSUM_W-1:0] r_bias, r_sum;
  logic [LANES*OUT_W-1:0] r_alpha, w_q;
  logic r_relu, r_v1, r_l1, r_v2, r_l2;
  logic [CW-1:0] w_cnt;
  logic w_re, w_last_rd, w_accept, w_hs_last;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  // credit: FIFO slots already promised to reads still in the two-stage pipeline
  assign w_re = r_state == RUN && int'(w_cnt) + int'(r_v1) + int'(r_v2) < FIFO_DEPTH;
  assign w_last_rd = r_idx == r_count - 1'b1;
  assign w_hs_last = out_valid && out_ready && out_last;
  assign re = w_re;
  assign ra = r_base + r_idx;
  assign busy = r_state == RUN || r_state == DRAIN;
  assign done = r_state == DONE;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PSUM_W-1:0] w_s, w_a;
    logic signed [47:0] w_p;
    logic signed [PSUM_W:0] w_t, w_r;
    assign w_s = lane_of(r_sum, g);
    assign w_p = w_s * $signed(r_alpha[OUT_W*(LANES-1-g) +: OUT_W]);
    assign w_a = r_relu && w_s[PSUM_W-1] ? w_p[PSUM_W+7:8] : w_s;
    assign w_t = {w_a[PSUM_W-1], w_a} + (PSUM_W+1)'(2 ** (FRAC_SHIFT - 1));
    assign w_r = w_t >>> FRAC_SHIFT;
    assign w_q[OUT_W*(LANES-1-g) +: OUT_W] = w_r > 33'sd32767 ? 16'h7FFF : w_r < -33'sd32768 ? 16'h8000 : w_r[OUT_W-1:0];
  end
  psum_out_fifo #(.DEPTH(FIFO_DEPTH), .W(LANES*OUT_W+1)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(r_v2),
    .wd({w_q, r_l2}),
    .rd_en(out_ready),
    .rdata({out_data, out_last}),
    .valid(out_valid),
    .cnt(w_cnt)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_base <= '0;
      r_count <= '0;
      r_idx <= '0;
      r_bias <= '0;
      r_alpha <= '0;
      r_relu <= 1'b0;
      r_sum <= '0;
      r_v1 <= 1'b0;
      r_l1 <= 1'b0;
      r_v2 <= 1'b0;
      r_l2 <= 1'b0;
    end else begin
      r_v1 <= w_re;
      r_l1 <= w_re && w_last_rd;
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      for (int i = 0; i < LANES; i++) r_sum[PSUM_W*(LANES-1-i) +: PSUM_W] <= lane_of(rd, i) + lane_of(r_bias, i);
      if (w_re) r_idx <= r_idx + 1'b1;
      if (w_accept) begin
        r_base <= base_addr;
        r_count <= count;
        r_bias <= bias;
        r_alpha <= alpha;
        r_relu <= relu_en;
        r_idx <= '0;
        r_state <= count == '0 ? DONE : RUN;
      end else begin
        r_state <= r_state == RUN ? (w_re && w_last_rd ? DRAIN : RUN) : r_state == DRAIN ? (w_hs_last ? DONE : DRAIN) : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: randomized scoreboard bench for psum_drain against a per-lane arithmetic reference
module tb_psum_drain;
  localparam int FRAC = 8;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, relu_en = 1'b0, out_ready;
  logic [15:0] base_addr = '0, count = '0, ra;
  logic [127:0] bias = '0, rd;
  logic [63:0] alpha = '0, out_data;
  logic re, out_valid, out_last, busy, done;

  psum_drain dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .bias(bias), .alpha(alpha), .relu_en(relu_en), .re(re), .ra(ra), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [int];
  logic [64:0] sb [$];
  logic [15:0] exp_ra [$];
  logic [15:0] e_ra;
  logic [64:0] e_beat;
  logic [63:0] prev_data, last_beat;
  logic prev_last;
  int checks = 0, errors = 0, cyc = 0, done_due = -1, rmode = 0, rcnt = 0;
  int issued = 0, accepted = 0, first_re = -1, beats = 0, prev_hs = 0;
  bit v_seen = 0, prev_stall = 0;

  task automatic chk(input bit ok, input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] rnd32();
    logic [31:0] r = $urandom;
    return r[0] ? r : {{12{r[19]}}, r[19:0]};
  endfunction

  // reference: plain integer arithmetic for one lane
  function automatic logic [15:0] ref_lane(input logic [31:0] p, input logic [31:0] b, input logic [15:0] a, input bit relu);
    int s = int'(p + b);
    longint t;
    if (relu && s < 0) s = int'((longint'(s) * longint'($signed(a))) >>> 8);
    t = (longint'(s) + (longint'(1) << (FRAC - 1))) >>> FRAC;
    return t > 32767 ? 16'h7FFF : t < -32768 ? 16'h8000 : 16'(t);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (re) rd <= mem.exists(int'(ra)) ? mem[int'(ra)] : '0;

  always @(posedge clk) begin
    #1;
    rcnt++;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : (rcnt % 2 == 0 && !(rcnt >= 12 && rcnt < 22));
  end

  always @(negedge clk) begin
    if (!rst) prev_stall = 0;
    else begin
      if (done || cyc == done_due) begin
        chk(done && cyc == done_due, "done_timing", 96'(done), 96'(cyc == done_due));
        chk(!busy, "busy_at_done", 96'(busy), 96'(0));
      end
      if (prev_stall)
        chk(out_valid && out_data == prev_data && out_last == prev_last, "stall_hold", {out_valid, out_data, out_last}, {1'b1, prev_data, prev_last});
      if (re) begin
        chk(issued - accepted < 4, "credit", 96'(issued - accepted), 96'(3));
        if (exp_ra.size() == 0) chk(0, "unexpected_re", 96'(ra), 96'(0));
        else begin
          e_ra = exp_ra.pop_front();
          chk(ra == e_ra, "ra", 96'(ra), 96'(e_ra));
        end
        if (first_re < 0) first_re = cyc;
        issued++;
      end
      if (out_valid && !v_seen) begin
        v_seen = 1;
        chk(cyc == first_re + 3, "latency", 96'(cyc - first_re), 96'(3));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk(0, "extra_beat", 96'({out_data, out_last}), 96'(0));
        else begin
          e_beat = sb.pop_front();
          chk({out_data, out_last} == e_beat, "beat", 96'({out_data, out_last}), 96'(e_beat));
          if (e_beat[0]) done_due = cyc + 1;
        end
        if (rmode == 0 && beats > 0) chk(cyc == prev_hs + 1, "beat_gap", 96'(cyc - prev_hs), 96'(1));
        last_beat = out_data;
        beats++;
        prev_hs = cyc;
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic launch(input logic [15:0] b_a, input logic [15:0] cnt, input logic [127:0] bi, input logic [63:0] al, input bit rl, input int mode, input bit fill);
    logic [15:0] ad;
    logic [127:0] w;
    logic [64:0] x;
    for (int i = 0; i < int'(cnt); i++) begin
      ad = b_a + 16'(i);
      if (fill) mem[int'(ad)] = {rnd32(), rnd32(), rnd32(), rnd32()};
      w = mem[int'(ad)];
      for (int l = 0; l < 4; l++) x[64-16*l -: 16] = ref_lane(w[127-32*l -: 32], bi[127-32*l -: 32], al[63-16*l -: 16], rl);
      x[0] = i == int'(cnt) - 1;
      exp_ra.push_back(ad);
      sb.push_back(x);
    end
    issued = 0; accepted = 0; first_re = -1; v_seen = 0; beats = 0; rmode = mode; rcnt = 0;
    base_addr = b_a; count = cnt; bias = bi; alpha = al; relu_en = rl; start = 1'b1;
    if (cnt == 0) done_due = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom); count = 16'($urandom); bias = {rnd32(), rnd32(), rnd32(), rnd32()};
    alpha = {$urandom, $urandom}; relu_en = 1'($urandom);
    chk(busy == (cnt != 0), "busy_after_start", 96'(busy), 96'(cnt != 0));
  endtask

  task automatic wait_done(input bit poke);
    int n = 0;
    while (!done && n < 3000) begin
      if (poke) start = n == 3 && busy;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) chk(0, "done_timeout", 96'(n), 96'(3000));
    chk(sb.size() == 0 && exp_ra.size() == 0, "drained", 96'(sb.size()), 96'(0));
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk({re, ra, out_valid, out_data, out_last, busy, done} == '0, "reset_state", 96'({re, ra, out_valid, out_data, out_last, busy, done}), 96'(0));
    rst = 1'b1;
    idle();
    mem[16'h0010] = {32'h0000_0180, 96'h0};
    launch(16'h0010, 16'd1, {32'h80, 96'h0}, 64'h0, 0, 0, 0);
    wait_done(0);
    chk(last_beat[63:48] == 16'h0002, "single_lane0", 96'(last_beat[63:48]), 96'h0002);
    idle();
    mem[16'h0020] = {32'h7FFF_0000, 32'h8000_0000, 32'hFFFF_FC00, 32'h0000_0180};
    launch(16'h0020, 16'd1, 128'h0, 64'h0, 0, 0, 0);
    wait_done(0);
    chk(last_beat == 64'h7FFF_8000_FFFC_0002, "saturate", 96'(last_beat), 96'h7FFF_8000_FFFC_0002);
    launch(16'h0020, 16'd1, 128'h0, {4{16'h0040}}, 1, 0, 0);
    wait_done(0);
    chk(last_beat == 64'h7FFF_8000_FFFF_0002, "prelu", 96'(last_beat), 96'h7FFF_8000_FFFF_0002);
    launch(16'h0100, 16'd8, {rnd32(), rnd32(), rnd32(), rnd32()}, {$urandom, $urandom}, 1, 0, 1);
    wait_done(1);
    launch(16'h0200, 16'd16, {rnd32(), rnd32(), rnd32(), rnd32()}, {$urandom, $urandom}, 1, 2, 1);
    wait_done(1);
    launch(16'hFFFE, 16'd4, {rnd32(), rnd32(), rnd32(), rnd32()}, {$urandom, $urandom}, 0, 1, 1);
    wait_done(0);
    idle();
    launch(16'h0300, 16'd0, 128'h0, 64'h0, 0, 0, 0);
    wait_done(0);
    launch(16'h0400, 16'd16, {rnd32(), rnd32(), rnd32(), rnd32()}, {$urandom, $urandom}, 1, 1, 1);
    repeat (6) idle();
    rst = 1'b0;
    idle();
    chk({re, ra, out_valid, out_data, out_last, busy, done} == '0, "reset_mid", 96'({re, ra, out_valid, out_data, out_last, busy, done}), 96'(0));
    sb.delete();
    exp_ra.delete();
    done_due = -1;
    rst = 1'b1;
    idle();
    for (int k = 0; k < 12; k++) begin
      launch(16'($urandom), 16'($urandom_range(1, 20)), {rnd32(), rnd32(), rnd32(), rnd32()}, {$urandom, $urandom},
             1'($urandom), $urandom_range(0, 2), 1);
      wait_done(1);
      if (k % 3 == 0) idle();
    end
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
